multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle combinational control unit. It owns the instruction register and a state machine that sequences fetch, decode, execute, memory and writeback over several cycles through one shared memory port with a ready handshake. It is generalised with:
- parametrised memory-wait timeout;
- optional Z-status branches;
- illegal-opcode and timeout error reporting.

It sits between the unified memory interface and the datapath (register file, ALU, PC mux).

---
 rtl/multicycle_control_pkg.sv | 70 +++++++
 rtl/multicycle_control_if.sv | 18 +
 rtl/multicycle_control_decode.sv | 67 ++++++
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, ALU op codes, opcode/funct values, error causes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXEC_R    = 4'd3,
        ST_EXEC_I    = 4'd4,
        ST_WB_ALU    = 4'd5,
        ST_MEM_ADDR  = 4'd6,
        ST_MEM_READ  = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_WB_MEM    = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_ERROR     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_MEM, CL_BR, CL_JUMP, CL_ILL
    } cls_e;

    typedef struct packed {
        cls_e    cls;
        alu_op_e alu_op;
        logic    ext_op;
        logic    illegal;
    } dec_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_BZ    = 6'h18;
    localparam logic [5:0] OPC_BN    = 6'h19;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multicycle_control_if.sv
// Unified memory port shared by instruction fetch and data access.
interface multicycle_control_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr_sel,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr_sel,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode/funct decoder: next-state class,
// ALU op and extension mode, plus an undecodable flag.
module multicycle_control_decode
    import multicycle_control_pkg::*;
#(
    parameter bit EXT_BRANCH = 1'b1
) (
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '{cls: CL_ILL, alu_op: OP_ADD,
                  ext_op: 1'b0, illegal: 1'b1};
        unique case (i_opcode)
            OPC_RTYPE: begin
                o_dec.cls     = CL_R;
                o_dec.illegal = 1'b0;
                unique case (i_funct)
                    FN_ADD:  o_dec.alu_op = OP_ADD;
                    FN_SUB:  o_dec.alu_op = OP_SUB;
                    FN_AND:  o_dec.alu_op = OP_AND;
                    FN_OR:   o_dec.alu_op = OP_OR;
                    FN_NOR:  o_dec.alu_op = OP_NOR;
                    FN_SLT:  o_dec.alu_op = OP_SLT;
                    FN_SLL:  o_dec.alu_op = OP_SLL;
                    FN_SRL:  o_dec.alu_op = OP_SRL;
                    FN_JR:   o_dec.cls    = CL_JUMP;
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            OPC_ADDI: begin
                o_dec = '{cls: CL_I, alu_op: OP_ADD,
                          ext_op: 1'b1, illegal: 1'b0};
            end
            OPC_ANDI: begin
                o_dec = '{cls: CL_I, alu_op: OP_AND,
                          ext_op: 1'b0, illegal: 1'b0};
            end
            OPC_ORI: begin
                o_dec = '{cls: CL_I, alu_op: OP_OR,
                          ext_op: 1'b0, illegal: 1'b0};
            end
            OPC_LW, OPC_SW: begin
                o_dec = '{cls: CL_MEM, alu_op: OP_ADD,
                          ext_op: 1'b1, illegal: 1'b0};
            end
            OPC_BEQ, OPC_BNE: begin
                o_dec = '{cls: CL_BR, alu_op: OP_SUB,
                          ext_op: 1'b1, illegal: 1'b0};
            end
            OPC_J, OPC_JAL: begin
                o_dec.cls     = CL_JUMP;
                o_dec.illegal = 1'b0;
            end
            OPC_BZ, OPC_BN: begin
                if (EXT_BRANCH) begin
                    o_dec.cls     = CL_BR;
                    o_dec.illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: owns IR, memory-wait timeout
// and sticky error reporting; drives datapath strobes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          EXT_BRANCH = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus,
    input  logic                        alu_zero,
    input  logic                        st_z,
    output logic [31:0]                 ir,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic [1:0]                  pc_select,
    output logic                        reg_write,
    output logic                        reg_dst,
    output logic                        write_reg31,
    output logic                        link,
    output logic                        alu_src,
    output logic [2:0]                  alu_op,
    output logic                        ext_op,
    output logic                        mem_to_reg,
    output logic                        error,
    output logic [1:0]                  error_code,
    output logic [3:0]                  state
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e          r_state;
    state_e          w_next;
    logic [31:0]     r_ir;
    logic [TW-1:0]   r_tcnt;
    logic [1:0]      r_err;
    logic [1:0]      w_err;
    logic            w_req;
    logic            w_we;
    logic            w_ads;
    logic            w_wait;
    logic            w_tmo;
    logic [5:0]      w_opc;
    dec_t            w_dec;

    assign w_opc  = r_ir[31:26];
    assign w_wait = w_req & ~bus.mem_ready;
    assign w_tmo  = (TIMEOUT != 0) && w_wait &&
                    (r_tcnt == TW'(TIMEOUT - 1));

    assign bus.mem_req      = w_req;
    assign bus.mem_we       = w_we;
    assign bus.mem_addr_sel = w_ads;
    assign ir               = r_ir;
    assign state            = r_state;
    assign error_code       = r_err;

    multicycle_control_decode #(
        .EXT_BRANCH (EXT_BRANCH)
    ) u_decode (
        .i_opcode (w_opc),
        .i_funct  (r_ir[5:0]),
        .o_dec    (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_tcnt  <= '0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_next;
            r_tcnt  <= w_wait ? r_tcnt + TW'(1) : '0;
            if (ir_write)
                r_ir <= bus.mem_rdata;
            // Only the first cause is latched; ERROR is terminal.
            if (w_next == ST_ERROR && r_state != ST_ERROR)
                r_err <= w_err;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_err       = ERR_NONE;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_ads       = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_select   = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        write_reg31 = 1'b0;
        link        = 1'b0;
        alu_src     = 1'b0;
        alu_op      = OP_ADD;
        ext_op      = 1'b0;
        mem_to_reg  = 1'b0;
        error       = 1'b0;
        unique case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                w_req = 1'b1;
                if (w_tmo) begin
                    w_next = ST_ERROR;
                    w_err  = ERR_TMO;
                end else if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                unique case (w_dec.cls)
                    CL_R:    w_next = ST_EXEC_R;
                    CL_I:    w_next = ST_EXEC_I;
                    CL_MEM:  w_next = ST_MEM_ADDR;
                    CL_BR:   w_next = ST_BRANCH;
                    CL_JUMP: w_next = ST_JUMP;
                    default: begin
                        w_next = ST_ERROR;
                        w_err  = ERR_ILL;
                    end
                endcase
            end
            ST_EXEC_R: begin
                alu_op = w_dec.alu_op;
                if (w_dec.illegal) begin
                    w_next = ST_ERROR;
                    w_err  = ERR_ILL;
                end else begin
                    w_next = ST_WB_ALU;
                end
            end
            ST_EXEC_I: begin
                alu_src = 1'b1;
                alu_op  = w_dec.alu_op;
                ext_op  = w_dec.ext_op;
                w_next  = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (w_dec.cls == CL_I);
                alu_src   = (w_dec.cls == CL_I);
                alu_op    = w_dec.alu_op;
                ext_op    = w_dec.ext_op;
                w_next    = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src = 1'b1;
                alu_op  = OP_ADD;
                ext_op  = 1'b1;
                w_next  = (w_opc == OPC_SW) ? ST_MEM_WRITE
                                            : ST_MEM_READ;
            end
            ST_MEM_READ, ST_MEM_WRITE: begin
                w_req = 1'b1;
                w_ads = 1'b1;
                w_we  = (r_state == ST_MEM_WRITE);
                if (w_tmo) begin
                    w_next = ST_ERROR;
                    w_err  = ERR_TMO;
                end else if (bus.mem_ready) begin
                    w_next = w_we ? ST_FETCH : ST_WB_MEM;
                end
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_BRANCH: begin
                w_next = ST_FETCH;
                if (w_opc == OPC_BZ || w_opc == OPC_BN) begin
                    pc_select = 2'b01;
                    pc_write  = st_z ^ (w_opc == OPC_BN);
                end else begin
                    alu_op    = OP_SUB;
                    pc_select = 2'b11;
                    pc_write  = alu_zero ^ (w_opc == OPC_BNE);
                end
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_select = (w_opc == OPC_RTYPE) ? 2'b10 : 2'b01;
                if (w_opc == OPC_JAL) begin
                    reg_write   = 1'b1;
                    write_reg31 = 1'b1;
                    link        = 1'b1;
                end
                w_next = ST_FETCH;
            end
            ST_ERROR: error = 1'b1;
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded cycle-by-cycle bench for multicycle_control.
module tb_multicycle_control;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_DEC = 4'd2;
    localparam logic [3:0] S_EXR = 4'd3;
    localparam logic [3:0] S_EXI = 4'd4;
    localparam logic [3:0] S_WBA = 4'd5;
    localparam logic [3:0] S_MADR = 4'd6;
    localparam logic [3:0] S_MRD = 4'd7;
    localparam logic [3:0] S_MWR = 4'd8;
    localparam logic [3:0] S_WBM = 4'd9;
    localparam logic [3:0] S_BR = 4'd10;
    localparam logic [3:0] S_JMP = 4'd11;
    localparam logic [3:0] S_ERR = 4'd12;

    localparam logic [19:0] REQ  = 20'h80000;
    localparam logic [19:0] WE   = 20'h40000;
    localparam logic [19:0] ADS  = 20'h20000;
    localparam logic [19:0] IRW  = 20'h10000;
    localparam logic [19:0] PCW  = 20'h08000;
    localparam logic [19:0] RW   = 20'h01000;
    localparam logic [19:0] RDST = 20'h00800;
    localparam logic [19:0] W31  = 20'h00400;
    localparam logic [19:0] LNK  = 20'h00200;
    localparam logic [19:0] ASRC = 20'h00100;
    localparam logic [19:0] EXT  = 20'h00010;
    localparam logic [19:0] M2R  = 20'h00008;
    localparam logic [19:0] ERR  = 20'h00004;
    localparam logic [19:0] SUB  = 20'h00020;

    function automatic logic [19:0] ps(input logic [1:0] v);
        return {5'b0, v, 13'b0};
    endfunction

    typedef struct {
        logic        rdy;
        logic        az;
        logic        sz;
        logic [3:0]  st;
        logic [19:0] c;
    } cyc_t;

    cyc_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        zero = 1'b0;
    logic        stz = 1'b0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    multicycle_control_if bus0 ();
    multicycle_control_if bus1 ();
    assign bus0.mem_ready = ready;
    assign bus0.mem_rdata = rdata;
    assign bus1.mem_ready = ready;
    assign bus1.mem_rdata = rdata;

    logic [31:0] ir, x_ir;
    logic ir_write, pc_write, reg_write, reg_dst, write_reg31;
    logic link, alu_src, ext_op, mem_to_reg, error;
    logic [1:0] pc_select, error_code;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic x_ir_write, x_pc_write, x_reg_write, x_reg_dst;
    logic x_write_reg31, x_link, x_alu_src, x_ext_op;
    logic x_mem_to_reg, x_error;
    logic [1:0] x_pc_select, x_error_code;
    logic [2:0] x_alu_op;
    logic [3:0] x_state;

    multicycle_control #(.TIMEOUT(4), .EXT_BRANCH(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .alu_zero(zero), .st_z(stz), .ir(ir),
        .ir_write(ir_write), .pc_write(pc_write),
        .pc_select(pc_select), .reg_write(reg_write),
        .reg_dst(reg_dst), .write_reg31(write_reg31),
        .link(link), .alu_src(alu_src), .alu_op(alu_op),
        .ext_op(ext_op), .mem_to_reg(mem_to_reg),
        .error(error), .error_code(error_code), .state(state)
    );

    multicycle_control #(.TIMEOUT(16), .EXT_BRANCH(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_zero(zero), .st_z(stz), .ir(x_ir),
        .ir_write(x_ir_write), .pc_write(x_pc_write),
        .pc_select(x_pc_select), .reg_write(x_reg_write),
        .reg_dst(x_reg_dst), .write_reg31(x_write_reg31),
        .link(x_link), .alu_src(x_alu_src), .alu_op(x_alu_op),
        .ext_op(x_ext_op), .mem_to_reg(x_mem_to_reg),
        .error(x_error), .error_code(x_error_code),
        .state(x_state)
    );

    logic [19:0] ctl;
    assign ctl = {bus0.mem_req, bus0.mem_we, bus0.mem_addr_sel,
                  ir_write, pc_write, pc_select, reg_write,
                  reg_dst, write_reg31, link, alu_src, alu_op,
                  ext_op, mem_to_reg, error, error_code};

    function automatic void push(input logic rdy, input logic az,
                                 input logic sz, input logic [3:0] st,
                                 input logic [19:0] c);
        cyc_t e;
        e.rdy = rdy; e.az = az; e.sz = sz; e.st = st; e.c = c;
        sb.push_back(e);
    endfunction

    // Drive the inputs of the oldest entry, sample one cycle.
    task automatic step(output logic [3:0] gs, output logic [19:0] gc);
        ready = sb[0].rdy;
        zero  = sb[0].az;
        stz   = sb[0].sz;
        @(negedge clk);
        gs = state;
        gc = ctl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== S_IDLE || ctl !== 20'h0 || ir !== 32'h0) begin
            errors++;
            $display("FAIL reset: state=%0d ctl=%05h ir=%08h expected 0 0 0",
                     state, ctl, ir);
        end
        checks++;
        if (x_state !== S_IDLE || x_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: state=%0d error=%0b expected 0 0",
                     x_state, x_error);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h2010FEFE;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_EXI, ASRC | EXT);
        push(1, 0, 0, S_WBA, RW | RDST | ASRC | EXT);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL addi: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        checks++;
        if (ir !== 32'h2010FEFE) begin
            errors++;
            $display("FAIL addi_ir: ir=%08h expected 2010fefe", ir);
        end
    endtask

    task automatic test_rtype();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h00430822;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_EXR, SUB);
        push(1, 0, 0, S_WBA, RW | SUB);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL rtype_sub: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        rdata = 32'h0000003F;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_EXR, 20'h0);
        push(1, 0, 0, S_ERR, ERR | 20'd1);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL bad_funct: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
    endtask

    task automatic test_lw();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h8C220000;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_MADR, ASRC | EXT);
        push(1, 0, 0, S_MRD, REQ | ADS);
        push(1, 0, 0, S_WBM, RW | RDST | M2R);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL lw: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
    endtask

    task automatic test_sw_wait();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'hAE100000;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_MADR, ASRC | EXT);
        for (int i = 0; i < 3; i++)
            push(0, 0, 0, S_MWR, REQ | WE | ADS);
        push(1, 0, 0, S_MWR, REQ | WE | ADS);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL sw_wait: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
    endtask

    task automatic test_branch();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h154BFFFC;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_BR, PCW | ps(2'b11) | SUB);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 1, 0, S_BR, ps(2'b11) | SUB);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL bne: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
    endtask

    task automatic test_jump();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h0C000004;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_JMP, PCW | ps(2'b01) | W31 | LNK | RW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL jal: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        rdata = 32'h03E00008;
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_JMP, PCW | ps(2'b10));
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL jr: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
    endtask

    task automatic test_errors();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h2010FEFE;
        do_reset();
        push(0, 0, 0, S_IDLE, 20'h0);
        for (int i = 0; i < 4; i++)
            push(0, 0, 0, S_FETCH, REQ);
        push(1, 0, 0, S_ERR, ERR | 20'd2);
        push(1, 0, 0, S_ERR, ERR | 20'd2);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL timeout: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        rdata = 32'hFC000000;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 0, S_ERR, ERR | 20'd1);
        push(1, 0, 0, S_ERR, ERR | 20'd1);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL illegal_op: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || error_code !== 2'b00 || state !== S_IDLE) begin
            errors++;
            $display("FAIL err_clear: error=%0b code=%0d state=%0d expected 0 0 0",
                     error, error_code, state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ext_branch();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'h60000010;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 1, S_BR, PCW | ps(2'b01));
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL bz: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        checks++;
        if (x_state !== S_ERR || x_error !== 1'b1 || x_error_code !== 2'b01) begin
            errors++;
            $display("FAIL bz_noext: state=%0d error=%0b code=%0d expected 12 1 1",
                     x_state, x_error, x_error_code);
        end
        rdata = 32'h64000000;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(1, 0, 1, S_BR, ps(2'b01));
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL bn: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
    endtask

    task automatic test_reset_abort();
        cyc_t e; logic [3:0] gs; logic [19:0] gc;
        rdata = 32'hAE100000;
        do_reset();
        push(1, 0, 0, S_IDLE, 20'h0);
        push(1, 0, 0, S_FETCH, REQ | IRW | PCW);
        push(1, 0, 0, S_DEC, 20'h0);
        push(0, 0, 0, S_MADR, ASRC | EXT);
        push(0, 0, 0, S_MWR, REQ | WE | ADS);
        while (sb.size() > 0) begin
            step(gs, gc);
            e = sb.pop_front();
            checks++;
            if (gs !== e.st || gc !== e.c) begin
                errors++;
                $display("FAIL abort_pre: state=%0d ctl=%05h expected state=%0d ctl=%05h",
                         gs, gc, e.st, e.c);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.mem_we !== 1'b0 || bus0.mem_req !== 1'b0 ||
            state !== S_IDLE || ir !== 32'h0) begin
            errors++;
            $display("FAIL abort: we=%0b req=%0b state=%0d ir=%08h expected 0 0 0 0",
                     bus0.mem_we, bus0.mem_req, state, ir);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jump();
        test_errors();
        test_ext_branch();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
